mem_rw_responder: RTL and testbench

Responder end of the start/finish memory-access handshake used by the RC4 algorithm FSMs. It accepts one read or write request at a time from an initiator (S, encrypted or decrypted memory side) and drives a single-port synchronous RAM with a configurable read latency. It returns read data and pulses finish. One instance sits between each algorithm FSM port and its RAM.

---
 rtl/mem_rw_responder_if.sv | 28 ++
 rtl/mem_rw_responder.sv | 111 +++++++++++
 tb/tb_mem_rw_responder.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_rw_responder_if.sv
// rtl/mem_rw_responder_if.sv - start/finish memory-access handshake plus RAM-side bus
interface mem_rw_responder_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic                  start_readWrite_op;
    logic                  readWrite;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  finish_readWrite_op;
    logic                  busy;
    logic [ADDR_WIDTH-1:0] ram_address;
    logic [DATA_WIDTH-1:0] ram_data;
    logic                  ram_wren;
    logic [DATA_WIDTH-1:0] ram_q;

    // Environment view: the initiator plus the RAM read port
    modport master (
        output start_readWrite_op, readWrite, address, data_in, ram_q,
        input  data_out, finish_readWrite_op, busy, ram_address, ram_data, ram_wren
    );

    modport slave (
        input  start_readWrite_op, readWrite, address, data_in, ram_q,
        output data_out, finish_readWrite_op, busy, ram_address, ram_data, ram_wren
    );
endinterface

// File: rtl/mem_rw_responder.sv
// rtl/mem_rw_responder.sv - single-request RAM responder for the RC4 FSM handshake
// Optional write read-back verification: MEMIF_READBACK_CHECK_EN
module mem_rw_responder #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic             clk,
    input  logic             reset,
    mem_rw_responder_if.slave bus,
    output logic             verify_error
);
    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE,
        RELEASE,
        VERIFY_ISSUE,
        VERIFY_WAIT
    } state_t;

    localparam logic [1:0] LAT_INIT = 2'(READ_LATENCY - 1);

    state_t     state;
    state_t     next_state;
    logic       rw_q;
    logic [1:0] lat_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.start_readWrite_op) next_state = ISSUE;
`ifdef MEMIF_READBACK_CHECK_EN
            ISSUE:   next_state = rw_q ? VERIFY_ISSUE : WAIT;
            VERIFY_ISSUE: next_state = VERIFY_WAIT;
            VERIFY_WAIT:  if (lat_cnt == 2'd0) next_state = DONE;
`else
            ISSUE:   next_state = rw_q ? DONE : WAIT;
`endif
            WAIT:    if (lat_cnt == 2'd0) next_state = DONE;
            DONE:    next_state = RELEASE;
            // A start still held high here must not launch another access
            RELEASE: if (!bus.start_readWrite_op) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.finish_readWrite_op = (state == DONE);
        bus.busy                = (state != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.ram_address <= '0;
            bus.ram_data    <= '0;
            bus.ram_wren    <= 1'b0;
            bus.data_out    <= '0;
            rw_q            <= 1'b0;
            lat_cnt         <= 2'd0;
`ifdef MEMIF_READBACK_CHECK_EN
            verify_error    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start_readWrite_op) begin
                        bus.ram_address <= bus.address;
                        bus.ram_data    <= bus.data_in;
                        rw_q            <= bus.readWrite;
                        bus.ram_wren    <= bus.readWrite;
                    end
                end
                ISSUE: begin
                    bus.ram_wren <= 1'b0;
                    lat_cnt      <= LAT_INIT;
                end
                WAIT: begin
                    if (lat_cnt == 2'd0) begin
                        bus.data_out <= bus.ram_q;
                    end else begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end
                end
`ifdef MEMIF_READBACK_CHECK_EN
                VERIFY_WAIT: begin
                    if (lat_cnt == 2'd0) begin
                        if (bus.ram_q != bus.ram_data) verify_error <= 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

`ifndef MEMIF_READBACK_CHECK_EN
    assign verify_error = 1'b0;
`endif
endmodule

// File: tb/tb_mem_rw_responder.sv
// tb/tb_mem_rw_responder.sv - directed bench: L=1 instance for main traffic, L=3 instance for reset abort
module tb_mem_rw_responder;
`ifdef MEMIF_READBACK_CHECK_EN
    localparam int WR_FIN = 4;
`else
    localparam int WR_FIN = 2;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;
    logic verr_a;
    logic verr_b;

    mem_rw_responder_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) a ();
    mem_rw_responder_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) b ();

    mem_rw_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .READ_LATENCY(1)) dut_a (
        .clk(clk), .reset(rst_a), .bus(a), .verify_error(verr_a)
    );
    mem_rw_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .READ_LATENCY(3)) dut_b (
        .clk(clk), .reset(rst_b), .bus(b), .verify_error(verr_b)
    );

    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];
    logic [7:0] q_a;
    logic [7:0] pipe_b [3];
    int wr_a  = 0;
    int fin_a = 0;
    int fin_b = 0;
    int n_vec = 0;
    int n_err = 0;

    // RAM A: one-cycle read latency, corrupts every write to 0x20
    always @(posedge clk) begin
        if (rst_a) begin
            mem_a[8'h10] <= 8'h3C;
            mem_a[8'h11] <= 8'h4D;
        end else if (a.ram_wren) begin
            mem_a[a.ram_address] <= (a.ram_address == 8'h20) ? ~a.ram_data : a.ram_data;
            wr_a <= wr_a + 1;
        end
        if (a.finish_readWrite_op) fin_a <= fin_a + 1;
        q_a <= mem_a[a.ram_address];
    end
    assign a.ram_q = q_a;

    always @(posedge clk) begin
        if (rst_b) begin
            mem_b[8'h10] <= 8'h9E;
        end else if (b.ram_wren) begin
            mem_b[b.ram_address] <= b.ram_data;
        end
        if (b.finish_readWrite_op) fin_b <= fin_b + 1;
        pipe_b[0] <= mem_b[b.ram_address];
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign b.ram_q = pipe_b[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic req_a(input logic rw, input logic [7:0] ad, input logic [7:0] d);
        a.start_readWrite_op = 1'b1;
        a.readWrite          = rw;
        a.address            = ad;
        a.data_in            = d;
    endtask

    task automatic wait_fin_a(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (a.finish_readWrite_op) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic release_a;
        a.start_readWrite_op = 1'b0;
        tick();
        tick();
    endtask

    int c;
    int w0;
    int f0;

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        req_a(1'b0, 8'h00, 8'h00);
        a.start_readWrite_op = 1'b0;
        b.start_readWrite_op = 1'b0;
        b.readWrite          = 1'b0;
        b.address            = 8'h00;
        b.data_in            = 8'h00;
        tick();
        tick();
        check("rst_busy", a.busy, 0);
        check("rst_finish", a.finish_readWrite_op, 0);
        check("rst_wren", a.ram_wren, 0);
        check("rst_addr", a.ram_address, 0);
        check("rst_dout", a.data_out, 0);
        check("rst_verr", verr_a, 0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        tick();

        // Write 0xA7 to 0x05
        req_a(1'b1, 8'h05, 8'hA7);
        tick();
        check("wr_c1_wren", a.ram_wren, 1);
        check("wr_c1_addr", a.ram_address, 8'h05);
        check("wr_c1_data", a.ram_data, 8'hA7);
        check("wr_c1_busy", a.busy, 1);
        wait_fin_a(c);
        check("wr_fin_cycle", c + 1, WR_FIN);
        check("wr_fin_wren", a.ram_wren, 0);
        release_a();
        check("wr_idle_busy", a.busy, 0);
        check("wr_idle_addr", a.ram_address, 8'h05);
        check("wr_count", wr_a, 1);

        // Read 0x10 at latency 1
        w0 = wr_a;
        req_a(1'b0, 8'h10, 8'h00);
        wait_fin_a(c);
        check("rd_fin_cycle", c, 3);
        check("rd_data", a.data_out, 8'h3C);
        release_a();
        check("rd_no_wren", wr_a, w0);
        check("rd_data_held", a.data_out, 8'h3C);

        // Start held high long after finish
        f0 = fin_a;
        w0 = wr_a;
        req_a(1'b1, 8'h30, 8'h66);
        wait_fin_a(c);
        check("hold_fin_cycle", c, WR_FIN);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_no_refinish", a.finish_readWrite_op, 0);
        end
        check("hold_fin_count", fin_a, f0 + 1);
        check("hold_wr_count", wr_a, w0 + 1);
        check("hold_busy", a.busy, 1);
        a.start_readWrite_op = 1'b0;
        tick();
        check("hold_idle", a.busy, 0);
        req_a(1'b0, 8'h11, 8'h00);
        tick();
        check("rearm_accept", a.busy, 1);
        wait_fin_a(c);
        check("rearm_fin_cycle", c + 1, 3);
        check("rearm_data", a.data_out, 8'h4D);
        release_a();

        // Start dropped after one cycle: write must still complete
        f0 = fin_a;
        req_a(1'b1, 8'hFF, 8'h01);
        tick();
        a.start_readWrite_op = 1'b0;
        check("early_wren", a.ram_wren, 1);
        check("early_addr", a.ram_address, 8'hFF);
        wait_fin_a(c);
        check("early_fin_cycle", c + 1, WR_FIN);
        tick();
        check("early_single_pulse", a.finish_readWrite_op, 0);
        tick();
        check("early_idle", a.busy, 0);
        check("early_fin_count", fin_a, f0 + 1);
        req_a(1'b0, 8'hFF, 8'h00);
        wait_fin_a(c);
        check("early_readback", a.data_out, 8'h01);
        release_a();

        // Write to the corrupting address
        req_a(1'b1, 8'h20, 8'h55);
        wait_fin_a(c);
        check("vfy_fin_cycle", c, WR_FIN);
        release_a();
`ifdef MEMIF_READBACK_CHECK_EN
        check("vfy_error_set", verr_a, 1);
        req_a(1'b1, 8'h40, 8'h77);
        wait_fin_a(c);
        check("vfy_good_fin", c, WR_FIN);
        release_a();
        check("vfy_error_sticky", verr_a, 1);
`else
        check("vfy_error_tied", verr_a, 0);
`endif

        // Reset during WAIT on the latency-3 instance
        b.start_readWrite_op = 1'b1;
        b.readWrite          = 1'b0;
        b.address            = 8'h10;
        tick();
        tick();
        tick();
        check("rstw_busy_pre", b.busy, 1);
        check("rstw_addr_pre", b.ram_address, 8'h10);
        f0 = fin_b;
        rst_b = 1'b1;
        #1;
        check("rstw_busy", b.busy, 0);
        check("rstw_finish", b.finish_readWrite_op, 0);
        check("rstw_wren", b.ram_wren, 0);
        check("rstw_addr", b.ram_address, 0);
        check("rstw_dout", b.data_out, 0);
        b.start_readWrite_op = 1'b0;
        tick();
        tick();
        rst_b = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("rstw_no_finish", fin_b, f0);
        b.start_readWrite_op = 1'b1;
        c = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (b.finish_readWrite_op) begin
                c = i;
                break;
            end
        end
        check("rstw_fin_cycle", c, 5);
        check("rstw_data", b.data_out, 8'h9E);
        b.start_readWrite_op = 1'b0;
        tick();
        tick();
        check("rstw_idle", b.busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
